clkgen_multi: RTL

- Parametrised successor of the PHY clock generator.
- Derives N_DIV divided clocks from the fundamental clock clk_8f_in using one down-counter.
- Adds per-edge tick strobes, count enable, a ready flag and a glitch-free selectable clock output (clk_sel).
- Sits in Modulo_Phy and feeds the serialiser/deserialiser lanes and the byte/word domains.

---
 rtl/clkgen_pkg.sv | 31 +++
 rtl/clkgen_sel_switch.sv | 118 +++++++++++
 rtl/clkgen_multi.sv | 101 ++++++++++
 3 files changed

// File: rtl/clkgen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clkgen_pkg
// Brief    : Shared constants, select-width helper and select-FSM states for
//            the multi-output PHY clock generator.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package clkgen_pkg;

    // Legal range for the number of divided outputs
    localparam int N_DIV_MIN = 1;
    localparam int N_DIV_MAX = 16;

    // Width of a select index able to address n outputs, never below 1
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Output-select state machine states
    typedef enum logic [0:0] {
        SEL_IDLE = 1'b0,
        SEL_PEND = 1'b1
    } sel_state_t;

endpackage
`default_nettype wire

// File: rtl/clkgen_sel_switch.sv
`default_nettype none
// ============================================================================
// Module   : clkgen_sel_switch
// Brief    : Glitch-free output selector. A new index is accepted in IDLE and
//            only committed on the counter wrap (all divided clocks rise
//            together), so clk_sel never produces a runt pulse.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module clkgen_sel_switch
    import clkgen_pkg::*;
#(
    parameter int N_DIV   = 3,
    parameter int SEL_RST = 0,
    parameter int SEL_W   = 2
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wrap,
    input  logic [N_DIV-1:0] cnt,
    input  logic [N_DIV-1:0] cnt_next,
    input  logic [SEL_W-1:0] sel_in,
    output logic             clk_sel,
    output logic             sel_busy,
    output logic             sel_err
);

    sel_state_t       r_state;
    sel_state_t       w_state_next;
    logic [SEL_W-1:0] r_sel_pend;
    logic [SEL_W-1:0] r_sel_active;
    logic [SEL_W-1:0] w_pend_next;
    logic [SEL_W-1:0] w_active_next;
    logic             r_sel_busy;
    logic             w_busy_next;
    logic             r_sel_err;
    logic             w_err_next;
    logic             r_clk_sel;
    logic             w_bit_next;
    logic             w_bit_hold;

    // Select state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEL_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept requests in IDLE, commit on the enabled wrap
    always_comb begin
        w_state_next  = r_state;
        w_pend_next   = r_sel_pend;
        w_active_next = r_sel_active;
        w_busy_next   = r_sel_busy;
        w_err_next    = 1'b0;
        case (r_state)
            SEL_IDLE: begin
                if (32'(sel_in) >= 32'(N_DIV)) begin
                    w_err_next = 1'b1;
                end else if (sel_in != r_sel_active) begin
                    w_pend_next  = sel_in;
                    w_busy_next  = 1'b1;
                    w_state_next = SEL_PEND;
                end
            end
            SEL_PEND: begin
                if (wrap) begin
                    w_active_next = r_sel_pend;
                    w_busy_next   = 1'b0;
                    w_state_next  = SEL_IDLE;
                end
            end
            default: begin
                w_state_next = SEL_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    // Pick the selected divided-clock bit; clk_div[k] lives in cnt[N_DIV-1-k]
    always_comb begin
        w_bit_next = 1'b0;
        w_bit_hold = 1'b0;
        for (int k = 0; k < N_DIV; k++) begin
            if (w_active_next == SEL_W'(k)) begin
                w_bit_next = cnt_next[N_DIV-1-k];
            end
            if (r_sel_active == SEL_W'(k)) begin
                w_bit_hold = cnt[N_DIV-1-k];
            end
        end
    end

    // Selector data registers; clk_sel follows the frozen counter when disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_pend   <= SEL_W'(SEL_RST);
            r_sel_active <= SEL_W'(SEL_RST);
            r_sel_busy   <= 1'b0;
            r_sel_err    <= 1'b0;
            r_clk_sel    <= 1'b0;
        end else begin
            r_sel_pend   <= w_pend_next;
            r_sel_active <= w_active_next;
            r_sel_busy   <= w_busy_next;
            r_sel_err    <= w_err_next;
            r_clk_sel    <= en ? w_bit_next : w_bit_hold;
        end
    end

    assign clk_sel  = r_clk_sel;
    assign sel_busy = r_sel_busy;
    assign sel_err  = r_sel_err;

endmodule
`default_nettype wire

// File: rtl/clkgen_multi.sv
`default_nettype none
// ============================================================================
// Module   : clkgen_multi
// Brief    : Derives N_DIV power-of-two divided clocks from clk_8f_in with a
//            single down-counter; adds rising-edge ticks, a ready flag and a
//            glitch-free selectable clock output.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module clkgen_multi
    import clkgen_pkg::*;
#(
    parameter int N_DIV   = 3,
    parameter int SEL_RST = 0,
    localparam int SEL_W  = sel_width(N_DIV)
)(
    input  logic             clk_8f_in,
    input  logic             resetCLK,
    input  logic             en,
    input  logic [SEL_W-1:0] sel_in,
    output logic             clk_8f,
    output logic [N_DIV-1:0] clk_div,
    output logic [N_DIV-1:0] tick,
    output logic             clk_sel,
    output logic             sel_busy,
    output logic             sel_err,
    output logic             ready
);

    // Elaboration-time parameter guard
    if (N_DIV < N_DIV_MIN || N_DIV > N_DIV_MAX || SEL_RST < 0 || SEL_RST >= N_DIV) begin : g_param_check
        $error("clkgen_multi: illegal N_DIV/SEL_RST");
    end

    logic [N_DIV-1:0] r_cnt;
    logic [N_DIV-1:0] w_cnt_dec;
    logic [N_DIV-1:0] w_div_dec;
    logic [N_DIV-1:0] r_tick;
    logic             r_ready;
    logic             w_wrap;

    assign w_cnt_dec = r_cnt - N_DIV'(1);
    assign w_wrap    = en && (r_cnt == '0);

    // clk_div[k] carries cnt[N_DIV-1-k], so bit 0 is the slowest clock
    for (genvar k = 0; k < N_DIV; k++) begin : g_rev
        assign clk_div[k]   = r_cnt[N_DIV-1-k];
        assign w_div_dec[k] = w_cnt_dec[N_DIV-1-k];
    end

    // Free-running down-counter, frozen while en is low
    always_ff @(posedge clk_8f_in) begin
        if (resetCLK) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_cnt_dec;
        end
    end

    // One-cycle strobe on every 0->1 transition of each divided clock
    always_ff @(posedge clk_8f_in) begin
        if (resetCLK) begin
            r_tick <= '0;
        end else if (en) begin
            r_tick <= w_div_dec & ~clk_div;
        end else begin
            r_tick <= '0;
        end
    end

    // Sticky ready once the counter first reaches zero
    always_ff @(posedge clk_8f_in) begin
        if (resetCLK) begin
            r_ready <= 1'b0;
        end else if (en && (w_cnt_dec == '0)) begin
            r_ready <= 1'b1;
        end
    end

    clkgen_sel_switch #(
        .N_DIV   (N_DIV),
        .SEL_RST (SEL_RST),
        .SEL_W   (SEL_W)
    ) u_sel_switch (
        .clk      (clk_8f_in),
        .rst      (resetCLK),
        .en       (en),
        .wrap     (w_wrap),
        .cnt      (r_cnt),
        .cnt_next (w_cnt_dec),
        .sel_in   (sel_in),
        .clk_sel  (clk_sel),
        .sel_busy (sel_busy),
        .sel_err  (sel_err)
    );

    assign clk_8f = clk_8f_in;
    assign tick   = r_tick;
    assign ready  = r_ready;

endmodule
`default_nettype wire
